rvfi_retire_assembler: RTL and testbench
========================================

Name: rvfi_retire_assembler

Overview:
- Builds in-order RVFI retirement packets for the execution tracer from the E21 testbench's core-side retire probes.
- Buffers retired instructions whose rd writeback arrives late (loads, divides), then merges the late data into the packet.
- Emits one packet per cycle in program order on the rvfi_* outputs, which feed the tracer directly.

Parameters:
- DEPTH, 4: number of in-flight retire entries; power of two, 2..16.
- XLEN, 32: data/address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- ret_valid  in  1  one instruction retired this cycle
- ret_pc  in  XLEN  PC of retired insn
- ret_pc_next  in  XLEN  next PC
- ret_insn  in  32  instruction word
- ret_rs1_addr, ret_rs2_addr  in  5  source regs
- ret_rs1_rdata, ret_rs2_rdata  in  XLEN  source values
- ret_rd_addr  in  5  destination reg
- ret_rd_wdata  in  XLEN  rd value; valid only when ret_wb_pending=0
- ret_wb_pending  in  1  rd value (and load data) arrives later on wb_*
- ret_mem_addr  in  XLEN  memory address
- ret_mem_rmask, ret_mem_wmask  in  4  byte masks
- ret_mem_wdata  in  XLEN  store data
- wb_valid  in  1  late writeback
- wb_rd_addr  in  5  late writeback register
- wb_data  in  XLEN  late rd value; also used as rvfi_mem_rdata
- rvfi_valid  out  1  packet valid, one-cycle pulse per insn
- rvfi_order  out  64  retirement index, starts at 0
- rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata  out  (RVFI widths)  packet fields
- overflow_o  out  1  sticky: retire dropped because buffer full
- wb_orphan_o  out  1  sticky: wb_valid with no pending entry

Behaviour:
- Reset (rst_ni=0 at posedge): all outputs 0, FIFO empty, all pending bits cleared, order counter 0. Reset mid-flight discards buffered entries; no packet is emitted afterwards for them.
- Storage: circular FIFO of DEPTH entries with head/tail pointers (log2 DEPTH bits, wrap) and a count of DEPTH+1 states. Each entry holds the ret_* fields plus a pending bit.
- Push: ret_valid and not full -> write entry at tail, pending=ret_wb_pending, tail++.
- Push when full: entry dropped, overflow_o set until reset. ret_valid cannot be back-pressured.
- Late writeback: wb_valid completes the oldest pending entry, found by priority search from head. It stores rd_wdata=wb_data, mem_rdata=wb_data if that entry's rmask!=0, then clears pending.
  - Same-cycle case: wb_valid while no entry is pending but ret_valid&ret_wb_pending -> the incoming entry is completed at push.
  - Otherwise wb_valid with no pending entry sets wb_orphan_o; the data is dropped.
- Pop: head entry non-pending -> registered outputs loaded, rvfi_valid=1 next cycle, head++, order++. Otherwise rvfi_valid=0 and outputs hold their last values.
- Push and pop in the same cycle are allowed, including when full (pop frees the slot first).
- Latency:
  - Non-pending retire into an empty FIFO at edge N -> rvfi_valid at N+1.
  - Pending entry at head completed by wb at edge M -> rvfi_valid at M+1.
- Ordering: a non-pending entry behind a pending head waits; strictly program order.
- rd_addr==0: rvfi_rd_wdata forced 0 regardless of source.
- Non-load entries: rvfi_mem_rdata=0.
- rvfi_order is 64-bit and wraps naturally.

Optional Feature:
- Macro: RVFI_ASM_RD_CHECK_EN.
- Defined: on each late writeback, wb_rd_addr is compared with the matched entry's rd_addr. A mismatch raises $error with both addresses and the entry PC, and sets extra output rd_mismatch_o (sticky, reset 0). The entry still completes with wb_data.
- Undefined: no comparison, no rd_mismatch_o port; wb_rd_addr is unused.

Test Plan:
- Reset then ret_valid, pc=0x80000000, insn=0x00500093, rd=x1, wdata=5, pending=0 -> next cycle rvfi_valid=1, order=0, rd_wdata=0x5, pc_wdata=ret_pc_next.
- Load at pc 0x100 (rmask=0xF, pending=1), then ALU at 0x104; wb_data=0xDEADBEEF 3 cycles later -> 0x100 packet with rd_wdata=mem_rdata=0xDEADBEEF, next cycle 0x104 packet; orders 0,1.
- Retire pending=1 with wb_valid in the same cycle, FIFO empty -> rvfi_valid next cycle with wb_data; wb_orphan_o stays 0.
- DEPTH=4: 4 pending retires, then a 5th retire with no pop -> overflow_o=1. Then 4 wbs -> exactly 4 packets in order.
- wb_valid with empty FIFO -> wb_orphan_o=1 and no rvfi_valid. Retire with rd=x0, wdata=0x1234 -> rvfi_rd_wdata=0.
- Reset asserted with 2 entries buffered -> no rvfi_valid after reset; next retire gets order=0.

Source files
------------

// File: rtl/rvfi_retire_assembler.sv
// rvfi_retire_assembler
//
// Assembles in-order RVFI retirement packets from core-side retire probes.
// Retired instructions are queued in a circular FIFO. Entries whose rd value
// (and load data) arrive later on the wb_* port stay pending until the oldest
// pending entry is completed. The head entry is emitted as a one-cycle
// rvfi_valid packet as soon as it is no longer pending.
//
// Parameters:
//   DEPTH  number of in-flight retire entries (power of two, 2..16)
//   XLEN   data/address width
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   ret_*                retire probe (one instruction per cycle, no stall)
//   wb_valid/rd_addr/data late rd writeback, also supplies load data
//   rvfi_*               registered RVFI packet outputs
//   overflow_o           sticky: a retire was dropped because the FIFO was full
//   wb_orphan_o          sticky: a writeback arrived with no pending entry
//   rd_mismatch_o        sticky, only with RVFI_ASM_RD_CHECK_EN defined:
//                        writeback register differs from the entry's rd
//
// Optional feature macro: RVFI_ASM_RD_CHECK_EN
module rvfi_retire_assembler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            ret_valid,
    input  logic [XLEN-1:0] ret_pc,
    input  logic [XLEN-1:0] ret_pc_next,
    input  logic [31:0]     ret_insn,
    input  logic [4:0]      ret_rs1_addr,
    input  logic [4:0]      ret_rs2_addr,
    input  logic [XLEN-1:0] ret_rs1_rdata,
    input  logic [XLEN-1:0] ret_rs2_rdata,
    input  logic [4:0]      ret_rd_addr,
    input  logic [XLEN-1:0] ret_rd_wdata,
    input  logic            ret_wb_pending,
    input  logic [XLEN-1:0] ret_mem_addr,
    input  logic [3:0]      ret_mem_rmask,
    input  logic [3:0]      ret_mem_wmask,
    input  logic [XLEN-1:0] ret_mem_wdata,

    input  logic            wb_valid,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_data,

    output logic            rvfi_valid,
    output logic [63:0]     rvfi_order,
    output logic [31:0]     rvfi_insn,
    output logic [XLEN-1:0] rvfi_pc_rdata,
    output logic [XLEN-1:0] rvfi_pc_wdata,
    output logic [4:0]      rvfi_rs1_addr,
    output logic [4:0]      rvfi_rs2_addr,
    output logic [XLEN-1:0] rvfi_rs1_rdata,
    output logic [XLEN-1:0] rvfi_rs2_rdata,
    output logic [4:0]      rvfi_rd_addr,
    output logic [XLEN-1:0] rvfi_rd_wdata,
    output logic [XLEN-1:0] rvfi_mem_addr,
    output logic [3:0]      rvfi_mem_rmask,
    output logic [3:0]      rvfi_mem_wmask,
    output logic [XLEN-1:0] rvfi_mem_rdata,
    output logic [XLEN-1:0] rvfi_mem_wdata,

    output logic            overflow_o,
`ifdef RVFI_ASM_RD_CHECK_EN
    output logic            rd_mismatch_o,
`endif
    output logic            wb_orphan_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
        logic [31:0]     insn;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [XLEN-1:0] rs1_rdata;
        logic [XLEN-1:0] rs2_rdata;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
        logic [XLEN-1:0] mem_addr;
        logic [3:0]      mem_rmask;
        logic [3:0]      mem_wmask;
        logic [XLEN-1:0] mem_rdata;
        logic [XLEN-1:0] mem_wdata;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [63:0]     order_cnt;

    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic            pend_found;
    logic [AW-1:0]   pend_idx;
    logic            wb_at_push;
    logic            wb_orphan;
    entry_t          new_ent;

    // Control: pop decisions use registered state only, so a writeback at
    // edge M makes its entry visible on rvfi_* one edge later.
    always_comb begin
        full       = (count == CW'(DEPTH));
        pop        = (count != '0) && !pend[head];
        // A pop in the same cycle frees the head slot, so a full FIFO can
        // still accept the incoming retire.
        push       = ret_valid && (!full || pop);
        drop       = ret_valid && full && !pop;

        // Oldest pending entry, searched from head within the live range.
        pend_found = 1'b0;
        pend_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!pend_found && (CW'(i) < count) && pend[head + AW'(i)]) begin
                pend_found = 1'b1;
                pend_idx   = head + AW'(i);
            end
        end

        wb_at_push = wb_valid && !pend_found && push && ret_wb_pending;
        wb_orphan  = wb_valid && !pend_found && !wb_at_push;
    end

    always_comb begin
        new_ent.pc        = ret_pc;
        new_ent.pc_next   = ret_pc_next;
        new_ent.insn      = ret_insn;
        new_ent.rs1_addr  = ret_rs1_addr;
        new_ent.rs2_addr  = ret_rs2_addr;
        new_ent.rs1_rdata = ret_rs1_rdata;
        new_ent.rs2_rdata = ret_rs2_rdata;
        new_ent.rd_addr   = ret_rd_addr;
        new_ent.rd_wdata  = ret_rd_wdata;
        new_ent.mem_addr  = ret_mem_addr;
        new_ent.mem_rmask = ret_mem_rmask;
        new_ent.mem_wmask = ret_mem_wmask;
        new_ent.mem_rdata = '0;
        new_ent.mem_wdata = ret_mem_wdata;
        if (wb_at_push) begin
            new_ent.rd_wdata = wb_data;
            if (ret_mem_rmask != '0) begin
                new_ent.mem_rdata = wb_data;
            end
        end
    end

    // Entry payload needs no reset: validity is tracked by count/pend.
    // The push slot never collides with the writeback slot: when full and
    // popping, tail equals head, which is non-pending.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[tail] <= new_ent;
        end
        if (wb_valid && pend_found) begin
            mem[pend_idx].rd_wdata <= wb_data;
            if (mem[pend_idx].mem_rmask != '0) begin
                mem[pend_idx].mem_rdata <= wb_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            pend        <= '0;
            overflow_o  <= 1'b0;
            wb_orphan_o <= 1'b0;
        end else begin
            if (push) begin
                pend[tail] <= ret_wb_pending && !wb_at_push;
                tail       <= tail + 1'b1;
            end
            if (wb_valid && pend_found) begin
                pend[pend_idx] <= 1'b0;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow_o <= 1'b1;
            end
            if (wb_orphan) begin
                wb_orphan_o <= 1'b1;
            end
        end
    end

    // Packet register: loaded on pop, otherwise holds the last packet.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvfi_valid     <= 1'b0;
            rvfi_order     <= '0;
            order_cnt      <= '0;
            rvfi_insn      <= '0;
            rvfi_pc_rdata  <= '0;
            rvfi_pc_wdata  <= '0;
            rvfi_rs1_addr  <= '0;
            rvfi_rs2_addr  <= '0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_rd_addr   <= '0;
            rvfi_rd_wdata  <= '0;
            rvfi_mem_addr  <= '0;
            rvfi_mem_rmask <= '0;
            rvfi_mem_wmask <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
        end else begin
            rvfi_valid <= pop;
            if (pop) begin
                rvfi_order     <= order_cnt;
                order_cnt      <= order_cnt + 64'd1;
                rvfi_insn      <= mem[head].insn;
                rvfi_pc_rdata  <= mem[head].pc;
                rvfi_pc_wdata  <= mem[head].pc_next;
                rvfi_rs1_addr  <= mem[head].rs1_addr;
                rvfi_rs2_addr  <= mem[head].rs2_addr;
                rvfi_rs1_rdata <= mem[head].rs1_rdata;
                rvfi_rs2_rdata <= mem[head].rs2_rdata;
                rvfi_rd_addr   <= mem[head].rd_addr;
                rvfi_rd_wdata  <= (mem[head].rd_addr == 5'd0) ? '0 : mem[head].rd_wdata;
                rvfi_mem_addr  <= mem[head].mem_addr;
                rvfi_mem_rmask <= mem[head].mem_rmask;
                rvfi_mem_wmask <= mem[head].mem_wmask;
                rvfi_mem_rdata <= (mem[head].mem_rmask == '0) ? '0 : mem[head].mem_rdata;
                rvfi_mem_wdata <= mem[head].mem_wdata;
            end
        end
    end

`ifdef RVFI_ASM_RD_CHECK_EN
    logic            wb_check;
    logic [4:0]      wb_exp_rd;
    logic [XLEN-1:0] wb_exp_pc;

    always_comb begin
        wb_check  = wb_valid && (pend_found || wb_at_push);
        wb_exp_rd = pend_found ? mem[pend_idx].rd_addr : ret_rd_addr;
        wb_exp_pc = pend_found ? mem[pend_idx].pc : ret_pc;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_mismatch_o <= 1'b0;
        end else if (wb_check && (wb_rd_addr != wb_exp_rd)) begin
            rd_mismatch_o <= 1'b1;
            $error("rvfi_retire_assembler: wb rd x%0d does not match entry rd x%0d (pc %h)",
                   wb_rd_addr, wb_exp_rd, wb_exp_pc);
        end
    end
`else
    logic unused_wb_rd;
    assign unused_wb_rd = ^wb_rd_addr;
`endif

endmodule

// File: tb/tb_rvfi_retire_assembler.sv
module tb_rvfi_retire_assembler;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            ret_valid;
    logic [31:0]     ret_pc, ret_pc_next, ret_insn;
    logic [4:0]      ret_rs1_addr, ret_rs2_addr, ret_rd_addr;
    logic [31:0]     ret_rs1_rdata, ret_rs2_rdata, ret_rd_wdata;
    logic            ret_wb_pending;
    logic [31:0]     ret_mem_addr, ret_mem_wdata;
    logic [3:0]      ret_mem_rmask, ret_mem_wmask;
    logic            wb_valid;
    logic [4:0]      wb_rd_addr;
    logic [31:0]     wb_data;

    logic            rvfi_valid;
    logic [63:0]     rvfi_order;
    logic [31:0]     rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata;
    logic [4:0]      rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0]     rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0]     rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [3:0]      rvfi_mem_rmask, rvfi_mem_wmask;
    logic            overflow_o, wb_orphan_o;
`ifdef RVFI_ASM_RD_CHECK_EN
    logic            rd_mismatch_o;
`endif

    always #5 clk = ~clk;

    rvfi_retire_assembler #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_pc_next(ret_pc_next),
        .ret_insn(ret_insn), .ret_rs1_addr(ret_rs1_addr), .ret_rs2_addr(ret_rs2_addr),
        .ret_rs1_rdata(ret_rs1_rdata), .ret_rs2_rdata(ret_rs2_rdata),
        .ret_rd_addr(ret_rd_addr), .ret_rd_wdata(ret_rd_wdata),
        .ret_wb_pending(ret_wb_pending), .ret_mem_addr(ret_mem_addr),
        .ret_mem_rmask(ret_mem_rmask), .ret_mem_wmask(ret_mem_wmask),
        .ret_mem_wdata(ret_mem_wdata),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata),
        .overflow_o(overflow_o),
`ifdef RVFI_ASM_RD_CHECK_EN
        .rd_mismatch_o(rd_mismatch_o),
`endif
        .wb_orphan_o(wb_orphan_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of retired instructions in program order.
    typedef struct {
        logic [31:0] pc, pcn, insn;
        logic [4:0]  rs1a, rs2a, rd;
        logic [31:0] rs1d, rs2d, wdata, maddr, mwdata, mrdata;
        logic [3:0]  rmask, wmask;
        bit          pend;
    } ent_t;

    ent_t        q[$];
    ent_t        last;
    bit          e_valid, e_ovf, e_orph;
    logic [63:0] e_order, ord_next;

    task automatic model_edge();
        ent_t n;
        bit   popv;
        bit   can_push;
        int   k;
        int   live;
        if (!rst_ni) begin
            q.delete();
            last     = '{default: 0};
            e_valid  = 0;
            e_order  = 0;
            ord_next = 0;
            e_ovf    = 0;
            e_orph   = 0;
        end else begin
            popv = (q.size() > 0) && !q[0].pend;
            k = -1;
            for (int i = 0; i < q.size(); i++)
                if (k < 0 && q[i].pend) k = i;
            n = '{pc: ret_pc, pcn: ret_pc_next, insn: ret_insn, rs1a: ret_rs1_addr,
                  rs2a: ret_rs2_addr, rd: ret_rd_addr, rs1d: ret_rs1_rdata,
                  rs2d: ret_rs2_rdata, wdata: ret_rd_wdata, maddr: ret_mem_addr,
                  mwdata: ret_mem_wdata, mrdata: 0, rmask: ret_mem_rmask,
                  wmask: ret_mem_wmask, pend: ret_wb_pending};
            live = q.size() - (popv ? 1 : 0);
            can_push = ret_valid && (live < DEPTH);
            if (wb_valid) begin
                if (k >= 0) begin
                    q[k].wdata = wb_data;
                    if (q[k].rmask != 0) q[k].mrdata = wb_data;
                    q[k].pend = 0;
                end else if (can_push && n.pend) begin
                    n.wdata = wb_data;
                    if (n.rmask != 0) n.mrdata = wb_data;
                    n.pend = 0;
                end else begin
                    e_orph = 1;
                end
            end
            if (ret_valid && !can_push) e_ovf = 1;
            e_valid = popv;
            if (popv) begin
                last     = q.pop_front();
                e_order  = ord_next;
                ord_next = ord_next + 1;
            end
            if (can_push) q.push_back(n);
        end
    endtask

    task automatic compare_all();
        check("valid",     rvfi_valid,     e_valid);
        check("order",     rvfi_order,     e_order);
        check("insn",      rvfi_insn,      last.insn);
        check("pc_rdata",  rvfi_pc_rdata,  last.pc);
        check("pc_wdata",  rvfi_pc_wdata,  last.pcn);
        check("rs1_addr",  rvfi_rs1_addr,  last.rs1a);
        check("rs2_addr",  rvfi_rs2_addr,  last.rs2a);
        check("rs1_rdata", rvfi_rs1_rdata, last.rs1d);
        check("rs2_rdata", rvfi_rs2_rdata, last.rs2d);
        check("rd_addr",   rvfi_rd_addr,   last.rd);
        check("rd_wdata",  rvfi_rd_wdata,  (last.rd == 0) ? 32'h0 : last.wdata);
        check("mem_addr",  rvfi_mem_addr,  last.maddr);
        check("mem_rmask", rvfi_mem_rmask, last.rmask);
        check("mem_wmask", rvfi_mem_wmask, last.wmask);
        check("mem_rdata", rvfi_mem_rdata, last.mrdata);
        check("mem_wdata", rvfi_mem_wdata, last.mwdata);
        check("overflow",  overflow_o,     e_ovf);
        check("wb_orphan", wb_orphan_o,    e_orph);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        rst_ni    = 1'b1;
        ret_valid = 1'b0;
        wb_valid  = 1'b0;
    endtask

    task automatic rand_ret(input bit pend);
        ret_valid      = 1'b1;
        ret_pc         = $urandom & 32'hFFFF_FFFC;
        ret_pc_next    = ret_pc + 32'd4;
        ret_insn       = $urandom;
        ret_rs1_addr   = 5'($urandom);
        ret_rs2_addr   = 5'($urandom);
        ret_rs1_rdata  = $urandom;
        ret_rs2_rdata  = $urandom;
        ret_rd_addr    = 5'($urandom);
        ret_rd_wdata   = $urandom;
        ret_wb_pending = pend;
        ret_mem_addr   = $urandom;
        ret_mem_rmask  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        ret_mem_wmask  = 4'($urandom);
        ret_mem_wdata  = $urandom;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    typedef struct {
        bit          rst, rv;
        logic [31:0] pc, insn;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [3:0]  rmask;
        bit          pend, wbv;
        logic [31:0] wbd;
        bit          ev;
        logic [63:0] eord;
        logic [31:0] epc, erd, emrd;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int          cnt;
        logic [31:0] pcs[$];

        tbl[0]  = '{0, 1, 32'h8000_0000, 32'h0050_0093, 5'd1, 32'h5, 4'h0, 0, 0, 32'h0, 0, 64'd0, 32'h0, 32'h0, 32'h0};
        tbl[1]  = '{0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 4'h0, 0, 0, 32'h0, 1, 64'd0, 32'h8000_0000, 32'h5, 32'h0};
        tbl[2]  = '{1, 0, 32'h0, 32'h0, 5'd0, 32'h0, 4'h0, 0, 0, 32'h0, 0, 64'd0, 32'h0, 32'h0, 32'h0};
        tbl[3]  = '{0, 1, 32'h100, 32'h0000_a103, 5'd2, 32'h0, 4'hF, 1, 0, 32'h0, 0, 64'd0, 32'h0, 32'h0, 32'h0};
        tbl[4]  = '{0, 1, 32'h104, 32'h0010_8193, 5'd3, 32'h7, 4'h0, 0, 0, 32'h0, 0, 64'd0, 32'h0, 32'h0, 32'h0};
        tbl[5]  = '{0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 4'h0, 0, 0, 32'h0, 0, 64'd0, 32'h0, 32'h0, 32'h0};
        tbl[6]  = '{0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 4'h0, 0, 1, 32'hDEAD_BEEF, 0, 64'd0, 32'h0, 32'h0, 32'h0};
        tbl[7]  = '{0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 4'h0, 0, 0, 32'h0, 1, 64'd0, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[8]  = '{0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 4'h0, 0, 0, 32'h0, 1, 64'd1, 32'h104, 32'h7, 32'h0};
        tbl[9]  = '{0, 1, 32'h200, 32'h0001_2203, 5'd4, 32'h0, 4'hF, 1, 1, 32'h55, 0, 64'd0, 32'h0, 32'h0, 32'h0};
        tbl[10] = '{0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 4'h0, 0, 0, 32'h0, 1, 64'd2, 32'h200, 32'h55, 32'h55};
        tbl[11] = '{0, 1, 32'h300, 32'h2340_0013, 5'd0, 32'h1234, 4'h0, 0, 0, 32'h0, 0, 64'd0, 32'h0, 32'h0, 32'h0};
        tbl[12] = '{0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 4'h0, 0, 0, 32'h0, 1, 64'd3, 32'h300, 32'h0, 32'h0};

        idle();
        rand_ret(0);
        ret_valid  = 1'b0;
        wb_rd_addr = 5'd0;
        wb_data    = 32'h0;
        do_reset();
        check("rst_valid", rvfi_valid, 0);
        check("rst_order", rvfi_order, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_orphan", wb_orphan_o, 0);

        // Directed table
        foreach (tbl[i]) begin
            rand_ret(tbl[i].pend);
            rst_ni        = !tbl[i].rst;
            ret_valid     = tbl[i].rv;
            ret_pc        = tbl[i].pc;
            ret_pc_next   = tbl[i].pc + 32'd4;
            ret_insn      = tbl[i].insn;
            ret_rd_addr   = tbl[i].rd;
            ret_rd_wdata  = tbl[i].wdata;
            ret_mem_rmask = tbl[i].rmask;
            wb_valid      = tbl[i].wbv;
            wb_data       = tbl[i].wbd;
            wb_rd_addr    = tbl[i].rd;
            step();
            check("tbl_valid", rvfi_valid, tbl[i].ev);
            check("tbl_orphan", wb_orphan_o, 0);
            if (tbl[i].ev) begin
                check("tbl_order", rvfi_order, tbl[i].eord);
                check("tbl_pc", rvfi_pc_rdata, tbl[i].epc);
                check("tbl_pc_wdata", rvfi_pc_wdata, tbl[i].epc + 32'd4);
                check("tbl_rd_wdata", rvfi_rd_wdata, tbl[i].erd);
                check("tbl_mem_rdata", rvfi_mem_rdata, tbl[i].emrd);
            end
        end
        idle();

        // Overflow: fill with pending entries, drop the 5th, then drain
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            rand_ret(1);
            ret_pc = 32'h400 + 32'(i * 4);
            step();
        end
        rand_ret(0);
        ret_pc = 32'h500;
        step();
        check("ovf_set", overflow_o, 1);
        idle();
        cnt = 0;
        pcs.delete();
        for (int i = 0; i < DEPTH + 6; i++) begin
            wb_valid = (i < DEPTH);
            wb_data  = $urandom;
            step();
            if (rvfi_valid) begin
                cnt++;
                pcs.push_back(rvfi_pc_rdata);
            end
        end
        check("ovf_pkt_count", 32'(cnt), 32'(DEPTH));
        for (int i = 0; i < pcs.size(); i++)
            check("ovf_pkt_pc", pcs[i], 32'h400 + 32'(i * 4));
        check("ovf_sticky", overflow_o, 1);

        // Orphan writeback on an empty FIFO
        do_reset();
        wb_valid = 1'b1;
        wb_data  = 32'hCAFE_0001;
        step();
        idle();
        check("orphan_set", wb_orphan_o, 1);
        cnt = rvfi_valid ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rvfi_valid) cnt++;
        end
        check("orphan_no_pkt", 32'(cnt), 0);

        // Reset with buffered entries discards them
        do_reset();
        rand_ret(1);
        step();
        rand_ret(1);
        step();
        idle();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            wb_valid = (i < 2);
            wb_data  = $urandom;
            step();
            if (rvfi_valid) cnt++;
        end
        check("flush_no_pkt", 32'(cnt), 0);
        idle();
        rand_ret(0);
        ret_pc = 32'h700;
        step();
        idle();
        step();
        check("flush_valid", rvfi_valid, 1);
        check("flush_order", rvfi_order, 0);
        check("flush_pc", rvfi_pc_rdata, 32'h700);

        // Randomized traffic against the queue model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rand_ret($urandom_range(0, 9) < 4);
            ret_valid  = ($urandom_range(0, 9) < 6);
            rst_ni     = ($urandom_range(0, 499) != 0);
            wb_valid   = ($urandom_range(0, 9) < 3);
            wb_data    = $urandom;
            wb_rd_addr = 5'($urandom);
            step();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
